// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: frame FSM states,
// scan-code prefix constants and the odd-parity helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_e;

  localparam logic [7:0] PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PREFIX_REL = 8'hF0;

  // PS/2 uses odd parity: data bits plus parity bit hold an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
    return ^{data, par};
  endfunction

endpackage

// File: rtl/ps2_filter.sv
// Two-flop synchronizer followed by a glitch filter for one PS/2 line.
// The output only follows the input after FILTER_LEN consecutive differing samples.
module ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic raw_i,
  output logic filt_o
);

  localparam int CNT_W = $clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             filt_q;
  logic             filt_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Count samples that disagree with the filtered level; any agreeing sample restarts the count.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync2_q != filt_q) begin
      if (cnt_q == CNT_LAST) begin
        filt_d = sync2_q;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Synchronizer and filter state; reset to the idle-high bus level.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      filt_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 keyboard receiver: filters the raw lines, deframes 11-bit frames,
// checks parity/stop/timeout and decodes E0/F0 prefixes into key events.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       CLK_25MHZ,
  input  logic       RESET_N,
  input  logic       PS2_CLK,
  input  logic       PS2_DATA,
  output logic [7:0] SCAN_CODE,
  output logic       SCAN_VALID,
  output logic [7:0] KEY_CODE,
  output logic       KEY_EXT,
  output logic       KEY_RELEASE,
  output logic       KEY_VALID,
  output logic       PARITY_ERR,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic            ps2_clk_f_s;
  logic            ps2_data_f_s;
  logic            fall_s;
  logic            clk_prev_q;
  ps2_state_e      state_q;
  logic [2:0]      bit_cnt_q;
  logic [7:0]      shift_q;
  logic            parity_q;
  logic [TO_W-1:0] to_q;
  logic            busy_q;
  logic [7:0]      scan_code_q;
  logic            scan_valid_q;
  logic            parity_err_q;
  logic            frame_err_q;
  logic [7:0]      key_code_q;
  logic            key_ext_q;
  logic            key_rel_q;
  logic            key_valid_q;
  logic            pend_ext_q;
  logic            pend_rel_q;

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_i   (CLK_25MHZ),
    .rst_n_i (RESET_N),
    .raw_i   (PS2_CLK),
    .filt_o  (ps2_clk_f_s)
  );

  ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filter (
    .clk_i   (CLK_25MHZ),
    .rst_n_i (RESET_N),
    .raw_i   (PS2_DATA),
    .filt_o  (ps2_data_f_s)
  );

  assign fall_s = clk_prev_q & ~ps2_clk_f_s;

  // Previous filtered clock level for falling-edge detection.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      clk_prev_q <= 1'b1;
    end else begin
      clk_prev_q <= ps2_clk_f_s;
    end
  end

  // Frame FSM with inter-edge timeout; a timeout overrides whatever the state would do.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'h00;
      parity_q     <= 1'b0;
      to_q         <= '0;
      busy_q       <= 1'b0;
      scan_code_q  <= 8'h00;
      scan_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;

      if (state_q == ST_IDLE || fall_s) begin
        to_q <= '0;
      end else begin
        to_q <= to_q + 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (fall_s && !ps2_data_f_s) begin
            state_q   <= ST_DATA;
            bit_cnt_q <= 3'd0;
            busy_q    <= 1'b1;
          end
        end
        ST_DATA: begin
          if (fall_s) begin
            shift_q   <= {ps2_data_f_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q <= ST_PARITY;
            end
          end
        end
        ST_PARITY: begin
          if (fall_s) begin
            parity_q <= ps2_data_f_s;
            state_q  <= ST_STOP;
          end
        end
        ST_STOP: begin
          if (fall_s) begin
            if (ps2_data_f_s && odd_parity_ok(shift_q, parity_q)) begin
              scan_code_q  <= shift_q;
              scan_valid_q <= 1'b1;
            end else if (!ps2_data_f_s) begin
              frame_err_q <= 1'b1;
            end else begin
              parity_err_q <= 1'b1;
            end
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase

      if (state_q != ST_IDLE && !fall_s && to_q == TO_LAST) begin
        state_q     <= ST_IDLE;
        busy_q      <= 1'b0;
        frame_err_q <= 1'b1;
      end
    end
  end

  // Prefix decoder: E0/F0 arm pending flags, any other code emits a key event.
  always_ff @(posedge CLK_25MHZ) begin
    if (!RESET_N) begin
      key_code_q  <= 8'h00;
      key_ext_q   <= 1'b0;
      key_rel_q   <= 1'b0;
      key_valid_q <= 1'b0;
      pend_ext_q  <= 1'b0;
      pend_rel_q  <= 1'b0;
    end else begin
      key_valid_q <= 1'b0;
      if (parity_err_q || frame_err_q) begin
        pend_ext_q <= 1'b0;
        pend_rel_q <= 1'b0;
      end else if (scan_valid_q) begin
        case (scan_code_q)
          PREFIX_EXT: pend_ext_q <= 1'b1;
          PREFIX_REL: pend_rel_q <= 1'b1;
          default: begin
            key_code_q  <= scan_code_q;
            key_ext_q   <= pend_ext_q;
            key_rel_q   <= pend_rel_q;
            key_valid_q <= 1'b1;
            pend_ext_q  <= 1'b0;
            pend_rel_q  <= 1'b0;
          end
        endcase
      end else begin
        pend_ext_q <= pend_ext_q;
        pend_rel_q <= pend_rel_q;
      end
    end
  end

  assign SCAN_CODE   = scan_code_q;
  assign SCAN_VALID  = scan_valid_q;
  assign KEY_CODE    = key_code_q;
  assign KEY_EXT     = key_ext_q;
  assign KEY_RELEASE = key_rel_q;
  assign KEY_VALID   = key_valid_q;
  assign PARITY_ERR  = parity_err_q;
  assign FRAME_ERR   = frame_err_q;
  assign BUSY        = busy_q;

endmodule

// File: tb/tb_ps2_receiver.sv
// Self-checking bench for ps2_receiver: directed scenarios plus random frames
// compared against a frame-level reference model of the receiver's rules.
module tb_ps2_receiver;

  localparam int HALF = 40;

  logic       clk;
  logic       rst_n;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] SCAN_CODE;
  logic       SCAN_VALID;
  logic [7:0] KEY_CODE;
  logic       KEY_EXT;
  logic       KEY_RELEASE;
  logic       KEY_VALID;
  logic       PARITY_ERR;
  logic       FRAME_ERR;
  logic       BUSY;

  int total = 0;
  int bad   = 0;

  int cyc = 0;
  int sv_cnt = 0, kv_cnt = 0, pe_cnt = 0, fe_cnt = 0, busy_cyc = 0;
  int excl_viol = 0, key_timing_viol = 0, fe_cyc = 0;
  logic [7:0] last_sv_code = 8'h00, kv_code = 8'h00;
  logic kv_ext = 1'b0, kv_rel = 1'b0, prev_sv = 1'b0;
  int last_edge_cyc = 0;

  logic [7:0] m_scan, m_key;
  logic m_ext, m_rel, m_pext, m_prel;
  bit exp_sv, exp_kv, exp_pe, exp_fe;

  ps2_receiver #(.FILTER_LEN(8), .TIMEOUT_CYCLES(5000)) dut (
    .CLK_25MHZ   (clk),
    .RESET_N     (rst_n),
    .PS2_CLK     (ps2_clk),
    .PS2_DATA    (ps2_data),
    .SCAN_CODE   (SCAN_CODE),
    .SCAN_VALID  (SCAN_VALID),
    .KEY_CODE    (KEY_CODE),
    .KEY_EXT     (KEY_EXT),
    .KEY_RELEASE (KEY_RELEASE),
    .KEY_VALID   (KEY_VALID),
    .PARITY_ERR  (PARITY_ERR),
    .FRAME_ERR   (FRAME_ERR),
    .BUSY        (BUSY)
  );

  initial clk = 1'b0;
  always #20 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder sampled on the falling edge of the system clock.
  always @(negedge clk) begin
    if (SCAN_VALID) begin
      sv_cnt       <= sv_cnt + 1;
      last_sv_code <= SCAN_CODE;
    end
    if (KEY_VALID) begin
      kv_cnt  <= kv_cnt + 1;
      kv_code <= KEY_CODE;
      kv_ext  <= KEY_EXT;
      kv_rel  <= KEY_RELEASE;
      if (!prev_sv) key_timing_viol <= key_timing_viol + 1;
    end
    if (PARITY_ERR) pe_cnt <= pe_cnt + 1;
    if (FRAME_ERR) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (int'(SCAN_VALID) + int'(PARITY_ERR) + int'(FRAME_ERR) > 1) excl_viol <= excl_viol + 1;
    if (BUSY) busy_cyc <= busy_cyc + 1;
    prev_sv <= SCAN_VALID;
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      wait_cycles(HALF);
      ps2_clk = 1'b0;
      last_edge_cyc = cyc;
      wait_cycles(HALF);
      ps2_clk = 1'b1;
    end
  endtask

  function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic par;
    par = ~(^b) ^ bad_par;
    return {~bad_stop, par, b, 1'b0};
  endfunction

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    send_bits(make_frame(b, bad_par, bad_stop), 11);
    ps2_data = 1'b1;
    wait_cycles(30);
  endtask

  task automatic model_reset();
    m_scan = 8'h00; m_key = 8'h00; m_ext = 1'b0; m_rel = 1'b0;
    m_pext = 1'b0; m_prel = 1'b0;
  endtask

  // Frame-level reference: what one complete frame must do to outputs and prefix state.
  task automatic model_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    exp_sv = 0; exp_kv = 0; exp_pe = 0; exp_fe = 0;
    if (bad_stop) begin
      exp_fe = 1; m_pext = 1'b0; m_prel = 1'b0;
    end else if (bad_par) begin
      exp_pe = 1; m_pext = 1'b0; m_prel = 1'b0;
    end else begin
      exp_sv = 1;
      m_scan = b;
      if (b == 8'hE0) m_pext = 1'b1;
      else if (b == 8'hF0) m_prel = 1'b1;
      else begin
        exp_kv = 1; m_key = b; m_ext = m_pext; m_rel = m_prel;
        m_pext = 1'b0; m_prel = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    ps2_clk = 1'b1; ps2_data = 1'b1; rst_n = 1'b0;
    model_reset();
    wait_cycles(5);
    total++;
    if ({SCAN_CODE, KEY_CODE} !== 16'h0000) begin
      bad++; $display("FAIL reset_codes: got %h want 0000", {SCAN_CODE, KEY_CODE});
    end
    total++;
    if ({SCAN_VALID, KEY_EXT, KEY_RELEASE, KEY_VALID, PARITY_ERR, FRAME_ERR, BUSY} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got %b want 0000000",
               {SCAN_VALID, KEY_EXT, KEY_RELEASE, KEY_VALID, PARITY_ERR, FRAME_ERR, BUSY});
    end
    rst_n = 1'b1;
    wait_cycles(20);
  endtask

  task automatic test_basic();
    int sv0, kv0;
    sv0 = sv_cnt; kv0 = kv_cnt;
    send_frame(8'h1C, 0, 0);
    model_frame(8'h1C, 0, 0);
    total++;
    if (sv_cnt - sv0 !== 1 || last_sv_code !== 8'h1C) begin
      bad++; $display("FAIL basic_scan: got n=%0d code=%h want n=1 code=1c", sv_cnt - sv0, last_sv_code);
    end
    total++;
    if (kv_cnt - kv0 !== 1 || {kv_code, kv_ext, kv_rel} !== {8'h1C, 2'b00}) begin
      bad++;
      $display("FAIL basic_key: got n=%0d code=%h ext=%b rel=%b want n=1 code=1c ext=0 rel=0",
               kv_cnt - kv0, kv_code, kv_ext, kv_rel);
    end
  endtask

  task automatic test_prefix();
    int sv0, kv0;
    sv0 = sv_cnt; kv0 = kv_cnt;
    send_frame(8'hE0, 0, 0); model_frame(8'hE0, 0, 0);
    send_frame(8'hF0, 0, 0); model_frame(8'hF0, 0, 0);
    send_frame(8'h75, 0, 0); model_frame(8'h75, 0, 0);
    total++;
    if (sv_cnt - sv0 !== 3) begin
      bad++; $display("FAIL prefix_scan_count: got %0d want 3", sv_cnt - sv0);
    end
    total++;
    if (kv_cnt - kv0 !== 1 || {KEY_CODE, KEY_EXT, KEY_RELEASE} !== {8'h75, 2'b11}) begin
      bad++;
      $display("FAIL prefix_key: got n=%0d code=%h ext=%b rel=%b want n=1 code=75 ext=1 rel=1",
               kv_cnt - kv0, KEY_CODE, KEY_EXT, KEY_RELEASE);
    end
    send_frame(8'h75, 0, 0); model_frame(8'h75, 0, 0);
    total++;
    if (kv_cnt - kv0 !== 2 || {KEY_CODE, KEY_EXT, KEY_RELEASE} !== {8'h75, 2'b00}) begin
      bad++;
      $display("FAIL prefix_plain: got n=%0d code=%h ext=%b rel=%b want n=2 code=75 ext=0 rel=0",
               kv_cnt - kv0, KEY_CODE, KEY_EXT, KEY_RELEASE);
    end
  endtask

  task automatic test_parity();
    int sv0, pe0, kv0;
    sv0 = sv_cnt; pe0 = pe_cnt; kv0 = kv_cnt;
    send_frame(8'h1C, 1, 0);
    model_frame(8'h1C, 1, 0);
    total++;
    if (pe_cnt - pe0 !== 1 || sv_cnt - sv0 !== 0 || kv_cnt - kv0 !== 0) begin
      bad++;
      $display("FAIL parity_err: got pe=%0d sv=%0d kv=%0d want pe=1 sv=0 kv=0",
               pe_cnt - pe0, sv_cnt - sv0, kv_cnt - kv0);
    end
    total++;
    if (SCAN_CODE !== 8'h75) begin
      bad++; $display("FAIL parity_hold: got %h want 75", SCAN_CODE);
    end
  endtask

  task automatic test_timeout();
    int fe0, sv0, k;
    fe0 = fe_cnt; sv0 = sv_cnt;
    send_bits(make_frame(8'h29, 0, 0), 5);
    total++;
    if (BUSY !== 1'b1) begin
      bad++; $display("FAIL timeout_busy_high: got %b want 1", BUSY);
    end
    k = 0;
    while (fe_cnt == fe0 && k < 6000) begin
      @(negedge clk);
      k++;
    end
    total++;
    if (fe_cnt - fe0 !== 1) begin
      bad++; $display("FAIL timeout_frame_err: got %0d pulses want 1", fe_cnt - fe0);
    end
    total++;
    if (fe_cyc - last_edge_cyc < 4995 || fe_cyc - last_edge_cyc > 5040) begin
      bad++; $display("FAIL timeout_delay: got %0d cycles want about 5000", fe_cyc - last_edge_cyc);
    end
    wait_cycles(2);
    total++;
    if (BUSY !== 1'b0 || sv_cnt - sv0 !== 0) begin
      bad++; $display("FAIL timeout_idle: got busy=%b sv=%0d want busy=0 sv=0", BUSY, sv_cnt - sv0);
    end
    model_frame(8'h00, 0, 1);
    ps2_data = 1'b1;
    wait_cycles(20);
    send_frame(8'h29, 0, 0);
    model_frame(8'h29, 0, 0);
    total++;
    if (sv_cnt - sv0 !== 1 || SCAN_CODE !== 8'h29 || KEY_CODE !== 8'h29) begin
      bad++;
      $display("FAIL timeout_recover: got n=%0d scan=%h key=%h want n=1 scan=29 key=29",
               sv_cnt - sv0, SCAN_CODE, KEY_CODE);
    end
  endtask

  task automatic test_glitch();
    int b0, sv0, pe0, fe0;
    ps2_data = 1'b0;
    wait_cycles(20);
    b0 = busy_cyc; sv0 = sv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
    ps2_clk = 1'b0;
    wait_cycles(5);
    ps2_clk = 1'b1;
    wait_cycles(30);
    ps2_data = 1'b1;
    wait_cycles(20);
    total++;
    if (busy_cyc - b0 !== 0 || sv_cnt - sv0 + pe_cnt - pe0 + fe_cnt - fe0 !== 0) begin
      bad++;
      $display("FAIL glitch_ignored: got busy_cycles=%0d events=%0d want 0 0",
               busy_cyc - b0, sv_cnt - sv0 + pe_cnt - pe0 + fe_cnt - fe0);
    end
  endtask

  task automatic test_reset_mid();
    logic [10:0] bits;
    int sv0;
    bits = make_frame(8'h5A, 0, 0);
    send_bits(bits, 9);
    @(negedge clk);
    ps2_data = bits[9];
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    wait_cycles(15);
    total++;
    if (BUSY !== 1'b1) begin
      bad++; $display("FAIL midreset_busy: got %b want 1", BUSY);
    end
    rst_n = 1'b0;
    wait_cycles(3);
    ps2_clk = 1'b1; ps2_data = 1'b1;
    wait_cycles(20);
    model_reset();
    total++;
    if ({SCAN_CODE, KEY_CODE, SCAN_VALID, KEY_EXT, KEY_RELEASE, KEY_VALID, PARITY_ERR, FRAME_ERR, BUSY}
        !== 23'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got scan=%h key=%h flags=%b want all zero", SCAN_CODE, KEY_CODE,
               {SCAN_VALID, KEY_EXT, KEY_RELEASE, KEY_VALID, PARITY_ERR, FRAME_ERR, BUSY});
    end
    rst_n = 1'b1;
    wait_cycles(20);
    sv0 = sv_cnt;
    send_frame(8'h1C, 0, 0);
    model_frame(8'h1C, 0, 0);
    total++;
    if (sv_cnt - sv0 !== 1 || SCAN_CODE !== 8'h1C) begin
      bad++; $display("FAIL midreset_recover: got n=%0d scan=%h want n=1 scan=1c", sv_cnt - sv0, SCAN_CODE);
    end
  endtask

  task automatic test_random();
    int sv0, kv0, pe0, fe0, r, e;
    logic [7:0] b;
    bit bp, bs;
    for (int it = 0; it < 24; it++) begin
      r = $urandom_range(0, 9);
      e = $urandom_range(0, 9);
      b = (r < 2) ? 8'hE0 : (r < 4) ? 8'hF0 : 8'($urandom_range(0, 255));
      bp = (e == 0);
      bs = (e == 1);
      sv0 = sv_cnt; kv0 = kv_cnt; pe0 = pe_cnt; fe0 = fe_cnt;
      send_frame(b, bp, bs);
      model_frame(b, bp, bs);
      total++;
      if (sv_cnt - sv0 !== int'(exp_sv) || kv_cnt - kv0 !== int'(exp_kv) ||
          pe_cnt - pe0 !== int'(exp_pe) || fe_cnt - fe0 !== int'(exp_fe)) begin
        bad++;
        $display("FAIL rand_events[%0d]: got sv=%0d kv=%0d pe=%0d fe=%0d want %0d %0d %0d %0d (byte %h)",
                 it, sv_cnt - sv0, kv_cnt - kv0, pe_cnt - pe0, fe_cnt - fe0,
                 exp_sv, exp_kv, exp_pe, exp_fe, b);
      end
      total++;
      if ({SCAN_CODE, KEY_CODE, KEY_EXT, KEY_RELEASE, BUSY} !== {m_scan, m_key, m_ext, m_rel, 1'b0}) begin
        bad++;
        $display("FAIL rand_outputs[%0d]: got scan=%h key=%h ext=%b rel=%b busy=%b want %h %h %b %b 0",
                 it, SCAN_CODE, KEY_CODE, KEY_EXT, KEY_RELEASE, BUSY, m_scan, m_key, m_ext, m_rel);
      end
    end
  endtask

  task automatic test_invariants();
    total++;
    if (excl_viol !== 0) begin
      bad++; $display("FAIL pulse_exclusive: got %0d overlapping cycles want 0", excl_viol);
    end
    total++;
    if (key_timing_viol !== 0) begin
      bad++; $display("FAIL key_after_scan: got %0d misplaced KEY_VALID want 0", key_timing_viol);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_prefix();
    test_parity();
    test_timeout();
    test_glitch();
    test_reset_mid();
    test_random();
    test_invariants();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
